// File: rtl/trace_stream_scheduler.sv
// Round-robin arbiter for two trace record producers feeding a small record FIFO,
// followed by a serialiser that emits each 160-bit record as five 32-bit TLAST-framed beats.
module trace_stream_scheduler #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TDATA_WIDTH = 32,
  parameter int unsigned REC_WIDTH   = 160
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          src0_valid,
  output logic                          src0_ready,
  input  logic [REC_WIDTH-1:0]          src0_record,
  input  logic                          src1_valid,
  output logic                          src1_ready,
  input  logic [REC_WIDTH-1:0]          src1_record,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [TDATA_WIDTH-1:0]        m_tdata,
  output logic                          m_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = PtrW + 1;
  localparam int unsigned NumBeats = REC_WIDTH / TDATA_WIDTH;
  localparam logic [2:0]  PreLast  = 3'(NumBeats - 2);

  typedef enum logic {StIdle, StSend} state_e;

  logic [REC_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 last_grant_q;
  state_e               state_q;
  logic [2:0]           beat_q;
  logic [REC_WIDTH-1:0] shift_q;
  logic                 tvalid_q, tlast_q;

  logic                 allow, grant0, grant1, push, pop, beat_hs, last_hs;
  logic [REC_WIDTH-1:0] push_rec;

  // last_grant_q = 1 means src1 was served last, so src0 wins a tie.
  assign allow    = enable && !rst && (count_q < CntW'(FIFO_DEPTH));
  assign grant0   = allow && src0_valid && (!src1_valid || last_grant_q);
  assign grant1   = allow && src1_valid && (!src0_valid || !last_grant_q);
  assign push     = grant0 || grant1;
  assign push_rec = grant0 ? src0_record : src1_record;

  assign beat_hs = tvalid_q && m_tready;
  assign last_hs = beat_hs && tlast_q;
  assign pop     = (count_q != '0) && ((state_q == StIdle) || last_hs);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      state_q      <= StIdle;
      beat_q       <= '0;
      shift_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_rec;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
        last_grant_q    <= grant1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + CntW'(push) - CntW'(pop);

      unique case (state_q)
        StIdle: begin
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            beat_q   <= '0;
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (beat_hs) begin
            if (tlast_q) begin
              // Reload straight from the FIFO so consecutive records have no bubble.
              if (pop) begin
                shift_q <= mem_q[rd_ptr_q];
                beat_q  <= '0;
                tlast_q <= 1'b0;
              end else begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                state_q  <= StIdle;
              end
            end else begin
              shift_q <= shift_q << TDATA_WIDTH;
              beat_q  <= beat_q + 3'd1;
              tlast_q <= (beat_q == PreLast);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign src0_ready = grant0;
  assign src1_ready = grant1;
  assign m_tvalid   = tvalid_q;
  assign m_tdata    = shift_q[REC_WIDTH-1 -: TDATA_WIDTH];
  assign m_tlast    = tlast_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: doc/trace_stream_scheduler.md
Name: trace_stream_scheduler

Overview:
- Shares the single trace output channel between two trace record producers: the instruction tracker (src0) and the data-memory tracker (src1).
- Arbitrates records round-robin into a small FIFO.
- Serialises each 160-bit trace_format record into five 32-bit beats on a valid/ready stream with TLAST.
- Sits between the Gouram trackers and the trace sink/DMA.

Parameters:
- FIFO_DEPTH, 4, record FIFO entries; power of two, minimum 2.
- TDATA_WIDTH, 32, output beat width; fixed at 32, equal to every trace_format field width.
- REC_WIDTH, 160, trace_format width (5 x 32); not to be overridden.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = accept new records; 0 = stop granting, drain the FIFO.
- src0_valid  in  1  instruction-tracker record valid.
- src0_ready  out  1  src0 record accepted this cycle.
- src0_record  in  160  trace_format record from src0.
- src1_valid  in  1  data-tracker record valid.
- src1_ready  out  1  src1 record accepted this cycle.
- src1_record  in  160  trace_format record from src1.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  sink ready.
- m_tdata  out  32  output beat.
- m_tlast  out  1  last beat of a record.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  FIFO non-empty or serialiser not IDLE.

Behaviour:
- Reset (rst=1 at clock edge): FIFO emptied, fifo_count=0, state=IDLE, beat=0, last_grant=1 (src0 wins first), m_tvalid=0, m_tdata=0, m_tlast=0, busy=0. srcN_ready is 0 while rst=1.
- Reset mid-record: the partial record and all FIFO contents are discarded; m_tvalid is 0 the cycle after reset.
- Arbitration is combinational and gates srcN_ready:
  - Grant is allowed only if enable=1 and fifo_count<FIFO_DEPTH. A full FIFO blocks push even when a pop occurs in the same cycle.
  - Only one valid source: that source is granted.
  - Both valid: the source != last_grant is granted.
  - srcN_ready=1 only for the granted source. A handshake is valid&&ready. last_grant updates on every handshake.
  - Producers must not make valid depend on ready, and must hold record stable until accepted.
- FIFO: push on handshake; pop when the serialiser loads a record; pointers wrap modulo FIFO_DEPTH.
- Serialiser FSM, states IDLE and SEND:
  - IDLE: if fifo_count!=0, load head into the output register, pop, set beat=0, go to SEND.
  - SEND: m_tvalid=1. m_tdata by beat: 0 = instruction, 1 = instr_addr, 2 = mem_addr, 3 = mem_trans_time_start, 4 = mem_trans_time_end (struct MSB-first order). m_tlast=1 only on beat 4.
  - SEND, on m_tvalid&&m_tready: beat increments.
  - SEND, on beat 4 handshake: if FIFO is non-empty, load the next record, set beat=0 and stay in SEND (back-to-back, no bubble); else go to IDLE and drop m_tvalid.
  - m_tdata and m_tlast hold stable while m_tvalid&&!m_tready.
- Latency with FIFO empty and in IDLE: handshake in cycle N; fifo_count=1 in cycle N+1; first beat m_tvalid=1 in cycle N+2.
- Sustained throughput: 1 record per 5 cycles with m_tready=1.
- enable=0: both readies 0; FIFO contents and the in-flight record continue draining.
- busy = (state!=IDLE) || (fifo_count!=0).
- No record is ever dropped or reordered within a source. Cross-source order equals grant order.

Test Plan:
- Reset, then src0 offers {instruction=0x00A00093, instr_addr=0x80, mem_addr=0, start=0x10, end=0x12} with m_tready=1 -> src0_ready=1 in cycle N; m_tvalid rises in N+2; beats 0x00A00093, 0x80, 0x0, 0x10, 0x12; m_tlast only on the 5th beat; busy=0 afterwards.
- src0 and src1 both valid for 6 records each, m_tready=1 -> first grant src0, then strictly alternating src1, src0, ...; output records in alternating order; back-to-back with no idle cycle between records.
- m_tready=0, 6 records offered from src1 -> 4 accepted into the FIFO plus 1 loaded in the serialiser; fifo_count peaks at 4 and src1_ready=0 while full; release m_tready -> all 5 records emerge intact, then the 6th is accepted.
- m_tready toggles 1,0,0,1,... mid-record -> m_tdata/m_tlast stable on stalled cycles; beat order unchanged.
- enable=0 with 3 records buffered -> readies stay 0; 3 records drained (15 beats); busy falls after the last beat.
- rst asserted during beat 2 with 2 records queued -> next cycle m_tvalid=0, fifo_count=0, busy=0; the next src1 record emerges with beat 0 first.
